// File: rtl/ascii_hex_parser.sv
// ASCII hex token parser: accumulates hex digits, emits value/count/err on a terminator.
// Define ASCII_HEX_LOWER_EN to accept lowercase a-f as digits.
module ascii_hex_parser #(
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_value,
    output logic [3:0]            out_count,
    output logic                  out_err
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_value_q, out_value_d;
    logic [3:0]     out_count_q, out_count_d;
    logic           out_err_q, out_err_d;

    logic           is_dig;
    logic           is_term;
    logic [3:0]     nib;
    logic           accept;

    always_comb begin
        is_dig  = 1'b0;
        is_term = 1'b0;
        nib     = 4'h0;
        if (in_data >= 8'h30 && in_data <= 8'h39) begin
            is_dig = 1'b1;
            nib    = in_data[3:0];
        end else if (in_data >= 8'h41 && in_data <= 8'h46) begin
            is_dig = 1'b1;
            nib    = in_data[3:0] + 4'd9;
`ifdef ASCII_HEX_LOWER_EN
        end else if (in_data >= 8'h61 && in_data <= 8'h66) begin
            is_dig = 1'b1;
            nib    = in_data[3:0] + 4'd9;
`endif
        end else if (in_data == 8'h0D || in_data == 8'h0A
                     || in_data == 8'h20) begin
            is_term = 1'b1;
        end
    end

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;
        out_count_d = out_count_q;
        out_err_d   = out_err_q;
        case (state_q)
            IDLE: begin
                if (accept && !is_term) begin
                    state_d = ACCUM;
                    if (is_dig) begin
                        acc_d = W'(nib);
                        cnt_d = 4'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (is_dig) begin
                        acc_d = W'({acc_q, nib});
                        // Full: keep the newest DIGITS digits, flag overflow
                        if (cnt_q == 4'(DIGITS)) begin
                            err_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (is_term) begin
                        out_value_d = acc_q;
                        out_count_d = cnt_q;
                        out_err_d   = err_q;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                        state_d     = HOLD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d       = '0;
                    cnt_d       = 4'd0;
                    err_d       = 1'b0;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= 4'd0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_count_q <= 4'd0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            out_count_q <= out_count_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_value = out_value_q;
    assign out_count = out_count_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Self-checking bench for ascii_hex_parser: directed token strings plus
// random character streams, compared against a string-level reference model.
module tb_ascii_hex_parser;

    localparam int DIGITS = 8;
    localparam int W = 4 * DIGITS;

    typedef struct packed {
        logic [W-1:0] v;
        logic [3:0]   c;
        logic         e;
    } res_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic [7:0]     in_data = 8'h00;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   out_value;
    logic [3:0]     out_count;
    logic           out_err;

    int checks = 0;
    int errors = 0;
    int valid_cycles = 0;
    bit rand_bp = 1'b0;

    res_t exp_q[$];
    res_t obs_q[$];

    ascii_hex_parser #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_count (out_count),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid === 1'b1) valid_cycles++;
        if (out_valid === 1'b1 && out_ready === 1'b1)
            obs_q.push_back('{out_value, out_count, out_err});
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Token-level reference: hex value kept as an integer modulo 2^W.
    function automatic void model(input string s);
        bit       tok = 0;
        longint   v = 0;
        int       c = 0;
        bit       e = 0;
        for (int i = 0; i < s.len(); i++) begin
            byte ch = s[i];
            int  n = -1;
            if (ch >= "0" && ch <= "9") n = ch - "0";
            else if (ch >= "A" && ch <= "F") n = ch - "A" + 10;
`ifdef ASCII_HEX_LOWER_EN
            else if (ch >= "a" && ch <= "f") n = ch - "a" + 10;
`endif
            if (ch == 8'h0D || ch == 8'h0A || ch == 8'h20) begin
                if (tok) begin
                    exp_q.push_back('{W'(v), 4'(c), e});
                    tok = 0; v = 0; c = 0; e = 0;
                end
            end else begin
                tok = 1;
                if (n >= 0) begin
                    v = (v * 16 + n) % (64'd1 << W);
                    if (c < DIGITS) c++;
                    else e = 1;
                end else begin
                    e = 1;
                end
            end
        end
    endfunction

    task automatic send_char(input byte ch);
        bit ok;
        int n = 0;
        in_valid = 1'b1;
        in_data  = ch;
        do begin
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 60);
        in_valid = 1'b0;
        if (!ok) chk("in_ready_timeout", 64'(n), 64'd0);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic drain_and_compare(input string tag);
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_nres"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk({tag, "_value"}, 64'(obs_q[i].v), 64'(exp_q[i].v));
            chk({tag, "_count"}, 64'(obs_q[i].c), 64'(exp_q[i].c));
            chk({tag, "_err"}, 64'(obs_q[i].e), 64'(exp_q[i].e));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic run_str(input string tag, input string s);
        model(s);
        send_str(s);
        drain_and_compare(tag);
    endtask

    initial begin
        int vc0;
        string alpha;
        string s;

        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_value", 64'(out_value), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic token with latency and single-cycle valid
        vc0 = valid_cycles;
        model("1A3F\r");
        send_str("1A3F");
        send_char(8'h0D);
        chk("lat_out_valid", 64'(out_valid), 64'd1);
        chk("lat_in_ready", 64'(in_ready), 64'd0);
        chk("basic_value", 64'(out_value), 64'h1A3F);
        chk("basic_count", 64'(out_count), 64'd4);
        @(posedge clk);
        #1;
        chk("hs_out_valid", 64'(out_valid), 64'd0);
        chk("hs_in_ready", 64'(in_ready), 64'd1);
        drain_and_compare("basic");
        chk("basic_valid_cycles", 64'(valid_cycles - vc0), 64'd1);

        run_str("ws", "  \n7 ");
        run_str("ovf", "123456789 ");
        run_str("inv", "12G4\n");
        run_str("allinv", "ZZ\r");
        run_str("lower", "ab\r");

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        model("FF ");
        send_str("FF ");
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_value", 64'(out_value), 64'hFF);
            @(posedge clk);
            #1;
        end
        drain_and_compare("bp");

        // Reset mid-token discards the partial token
        send_str("AB");
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_out_value", 64'(out_value), 64'd0);
        chk("mrst_out_count", 64'(out_count), 64'd0);
        chk("mrst_out_err", 64'(out_err), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_char(8'h20);
        drain_and_compare("mrst_none");
        run_str("post_rst", "5\r");

        // Random character streams with random downstream stalls
        alpha = "0123456789ABCDEFabcdefGz!\r\n  ";
        for (int t = 0; t < 12; t++) begin
            s = "";
            for (int i = 0; i < 40; i++) begin
                s = {s, " "};
                s.putc(s.len() - 1, alpha[$urandom_range(0, alpha.len() - 1)]);
            end
            s = {s, "\r"};
            model(s);
            rand_bp = 1'b1;
            send_str(s);
            drain_and_compare("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ascii_hex_parser.md
# ascii_hex_parser

Converts a stream of ASCII characters into binary: it accumulates hexadecimal digit characters into a `4*DIGITS`-bit value and emits that value with a digit count and an error flag when a terminator arrives. It sits between the UART receive byte stream and the command/data logic. It is the inverse path of the nibble-to-ASCII display encoder used on the transmit side.

## Interface
- `DIGITS`, default 8: maximum hex digits per token (legal range 1..15); the output value is `4*DIGITS` bits wide.
- `clk`  input  1  system clock; all logic is rising-edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  `in_data` holds a character.
- `in_data`  input  8  ASCII character.
- `in_ready`  output  1  parser can accept a character; a character is consumed on a cycle where `in_valid && in_ready`.
- `out_valid`  output  1  a token result is presented.
- `out_ready`  input  1  downstream accepts the result; the result is consumed on a cycle where `out_valid && out_ready`.
- `out_value`  output  4*DIGITS  parsed value, right-aligned and zero-extended.
- `out_count`  output  4  number of digits held in `out_value` (0..DIGITS).
- `out_err`  output  1  the token contained an invalid character or overflowed.

## Operation
- Character classes:
  - Digit: `0x30`–`0x39` map to 0–9; `0x41`–`0x46` map to A–F; `0x61`–`0x66` map to a–f only when the lowercase option is enabled (see Configuration).
  - Terminator: `0x0D` (CR), `0x0A` (LF), `0x20` (space).
  - Invalid: any other byte.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE, accepting a character:
  - Terminator: ignored, so leading whitespace and blank lines are skipped.
  - Digit: `acc = nibble`, `cnt = 1`; go to ACCUM.
  - Invalid: set `err`; go to ACCUM.
- ACCUM, accepting a character:
  - Digit: `acc = {acc[4*DIGITS-5:0], nibble}`. If `cnt == DIGITS`, set `err` sticky and leave `cnt` unchanged, so the value keeps the last DIGITS digits. Otherwise increment `cnt`.
  - Invalid: set `err`; `acc` and `cnt` are unchanged; stay in ACCUM.
  - Terminator: latch `acc`, `cnt`, `err` into `out_value`, `out_count`, `out_err`; go to HOLD.
- HOLD:
  - `out_valid = 1`; `in_ready = 0`.
  - On handshake: clear `acc`, `cnt`, `err`; go to IDLE.
- `in_ready = 1` in IDLE and ACCUM; `in_ready = 0` in HOLD.
- The outputs are stable while `out_valid && !out_ready`.
- A token made only of invalid characters is emitted with `out_count = 0` and `out_err = 1`.

## Timing
- All outputs are registered. Reset values: `out_valid = 0`, `out_value = 0`, `out_count = 0`, `out_err = 0`, `in_ready = 1`; FSM in IDLE; `acc`, `cnt`, `err` all 0.
- Latency: a terminator accepted at edge N gives `out_valid = 1` after edge N; the result is visible in cycle N+1.
- `in_ready` drops in the same cycle `out_valid` rises.
- If `out_ready` is already high, the handshake completes in cycle N+1. `in_ready` returns to 1 in cycle N+2. Throughput is one token per (characters + 1) cycles minimum.
- A character may be accepted on every cycle while in IDLE/ACCUM; there are no bubbles.
- Reset asserted mid-token or during HOLD discards all state immediately and asynchronously. No partial result is emitted after release.
- `in_valid` with `in_ready = 0` is not consumed; the sender must hold the character.

## Configuration
- `ASCII_HEX_LOWER_EN`:
  - Defined: `0x61`–`0x66` are digits 10–15.
  - Undefined: those bytes are Invalid and set `err`.
  - All other behaviour is identical in both builds.

## Test plan
- Basic token: send "1A3F\r" with `out_ready = 1` -> one result, `out_value = 0x00001A3F`, `out_count = 4`, `out_err = 0`, `out_valid` high exactly one cycle.
- Whitespace skipping: send "  \n7 " -> one result, `out_value = 0x7`, `out_count = 1`; the leading spaces and LF produce no output.
- Overflow (`DIGITS = 8`): send "123456789 " -> `out_value = 0x23456789`, `out_count = 8`, `out_err = 1`.
- Invalid character: send "12G4\n" -> `out_value = 0x124`, `out_count = 3`, `out_err = 1`. Send "ZZ\r" -> `out_count = 0`, `out_err = 1`.
- Backpressure then reset: send "FF " with `out_ready = 0` for 5 cycles -> `in_ready = 0` and `out_value = 0xFF` stable throughout. Then send "AB" and pulse `rst_n` low before its terminator -> all outputs return to reset values and no result is emitted.
- Lowercase: send "ab\r" -> with `ASCII_HEX_LOWER_EN`: `0xAB`, `out_err = 0`; without it: `out_count = 0`, `out_err = 1`.
